// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding select codes and multi-cycle scoreboard states
package hazard_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_e;
endpackage

// File: rtl/mc_scoreboard.sv
// mc_scoreboard: countdown tracker for the single iterative MUL/DIV unit
// Ports: issue_i/id_rd_i start an op; mc_busy_o (BUSY or DONE), mc_struct_o (BUSY only,
// the structural-conflict view), mc_rd_o destination, mc_done_o writeback pulse.
// HAZARD_STATS_EN adds mc_issue_cnt_o, a saturating issue counter.
module mc_scoreboard import hazard_pkg::*; #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_i,
  input  logic [REG_AW-1:0] id_rd_i,
  output logic              mc_busy_o,
  output logic              mc_struct_o,
  output logic              mc_done_o,
  output logic [REG_AW-1:0] mc_rd_o
`ifdef HAZARD_STATS_EN
  ,output logic [31:0]      mc_issue_cnt_o
`endif
);
  localparam logic [3:0] LOAD = 4'(MC_LAT - 1);
  mc_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  always_ff @(posedge clk_i)
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  // DONE is entered when the counter will read 1, so the pulse lands MC_LAT-1 cycles after issue
  always_comb begin
    state_d = IDLE;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    if (state_q == BUSY) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = (cnt_d == 4'd1) ? DONE : BUSY;
    end else if (issue_i) begin
      cnt_d   = LOAD;
      rd_d    = id_rd_i;
      state_d = (LOAD == 4'd1) ? DONE : BUSY;
    end
  end
  assign mc_busy_o   = state_q != IDLE;
  assign mc_struct_o = state_q == BUSY;
  assign mc_done_o   = state_q == DONE;
  assign mc_rd_o     = rd_q;
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk_i)
    if (!rst_i) mc_issue_cnt_o <= '0;
    else if (issue_i && ~&mc_issue_cnt_o) mc_issue_cnt_o <= mc_issue_cnt_o + 32'd1;
`endif
endmodule

// File: rtl/scoreboard_fwd_unit.sv
// scoreboard_fwd_unit: EX operand forwarding, load-use and multi-cycle hazard stall control
// Ports: ex_*/mem_*/wb_* pipeline tags drive fwd_o (2 bits per operand); id_* drive stall_o
// and multi-cycle issue; mc_* report the in-flight MUL/DIV op.
// HAZARD_STATS_EN adds stall_cnt_o and mc_issue_cnt_o saturating counters.
module scoreboard_fwd_unit import hazard_pkg::*; #(
  parameter int REG_AW = 5,
  parameter int NUM_RS = 2,
  parameter int MC_LAT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     id_valid_i,
  input  logic [NUM_RS*REG_AW-1:0] id_rs_i,
  input  logic [NUM_RS-1:0]        id_rs_used_i,
  input  logic [REG_AW-1:0]        id_rd_i,
  input  logic                     id_mc_i,
  input  logic [NUM_RS*REG_AW-1:0] ex_rs_i,
  input  logic                     ex_regwrite_i,
  input  logic                     ex_memread_i,
  input  logic [REG_AW-1:0]        ex_rd_i,
  input  logic                     mem_regwrite_i,
  input  logic [REG_AW-1:0]        mem_rd_i,
  input  logic                     wb_regwrite_i,
  input  logic [REG_AW-1:0]        wb_rd_i,
  output logic [2*NUM_RS-1:0]      fwd_o,
  output logic                     stall_o,
  output logic                     mc_busy_o,
  output logic [REG_AW-1:0]        mc_rd_o,
  output logic                     mc_done_o
`ifdef HAZARD_STATS_EN
  ,output logic [31:0]             stall_cnt_o,
  output logic [31:0]              mc_issue_cnt_o
`endif
);
  logic [NUM_RS-1:0] lu_hit, raw_hit;
  logic mc_struct, load_use, mc_haz, issue;
  for (genvar k = 0; k < NUM_RS; k++) begin : g_rs
    logic [REG_AW-1:0] ers, irs;
    assign ers = ex_rs_i[k*REG_AW +: REG_AW];
    assign irs = id_rs_i[k*REG_AW +: REG_AW];
    assign fwd_o[2*k +: 2] = (mem_regwrite_i && mem_rd_i != '0 && mem_rd_i == ers) ? FWD_MEM :
                             (wb_regwrite_i && wb_rd_i != '0 && wb_rd_i == ers) ? FWD_WB : FWD_RF;
    assign lu_hit[k]  = id_rs_used_i[k] && irs == ex_rd_i;
    assign raw_hit[k] = id_rs_used_i[k] && irs == mc_rd_o;
  end
  assign load_use = ex_memread_i && ex_rd_i != '0 && |lu_hit;
  // RAW is waived in the DONE cycle (writeback forwards it); structural only blocks in BUSY
  assign mc_haz = mc_busy_o && ((|raw_hit && mc_rd_o != '0 && !mc_done_o) ||
                                (id_rd_i == mc_rd_o && id_rd_i != '0) || (id_mc_i && mc_struct));
  assign stall_o = id_valid_i && (load_use || mc_haz);
  assign issue   = id_valid_i && id_mc_i && !stall_o;
  mc_scoreboard #(.REG_AW(REG_AW), .MC_LAT(MC_LAT)) u_mc (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .issue_i     (issue),
    .id_rd_i     (id_rd_i),
    .mc_busy_o   (mc_busy_o),
    .mc_struct_o (mc_struct),
    .mc_done_o   (mc_done_o),
    .mc_rd_o     (mc_rd_o)
`ifdef HAZARD_STATS_EN
    ,.mc_issue_cnt_o (mc_issue_cnt_o)
`endif
  );
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk_i)
    if (!rst_i) stall_cnt_o <= '0;
    else if (stall_o && ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + 32'd1;
`endif
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite_i;
endmodule

// File: tb/tb_scoreboard_fwd_unit.sv
// tb_scoreboard_fwd_unit: directed vectors with a queued expectation scoreboard
module tb_scoreboard_fwd_unit;
  logic clk = 1'b0;
  logic rst_i, id_valid_i, id_mc_i, ex_regwrite_i, ex_memread_i, mem_regwrite_i, wb_regwrite_i;
  logic [9:0] id_rs_i, ex_rs_i;
  logic [1:0] id_rs_used_i;
  logic [4:0] id_rd_i, ex_rd_i, mem_rd_i, wb_rd_i, mc_rd_o;
  logic [3:0] fwd_o;
  logic stall_o, mc_busy_o, mc_done_o;
  logic [31:0] sc_o, ic_o;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_o, mc_issue_cnt_o;
  assign sc_o = stall_cnt_o;
  assign ic_o = mc_issue_cnt_o;
`else
  assign sc_o = '0;
  assign ic_o = '0;
`endif
  int checks = 0, errors = 0;
  typedef struct {
    string nm;
    logic [3:0] f;
    logic s, b, d;
    logic [4:0] r;
    logic hs;
    logic [31:0] sc, ic;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  scoreboard_fwd_unit dut (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
    .id_rs_used_i(id_rs_used_i), .id_rd_i(id_rd_i), .id_mc_i(id_mc_i), .ex_rs_i(ex_rs_i),
    .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .mem_regwrite_i(mem_regwrite_i), .mem_rd_i(mem_rd_i), .wb_regwrite_i(wb_regwrite_i),
    .wb_rd_i(wb_rd_i), .fwd_o(fwd_o), .stall_o(stall_o), .mc_busy_o(mc_busy_o),
    .mc_rd_o(mc_rd_o), .mc_done_o(mc_done_o)
`ifdef HAZARD_STATS_EN
    , .stall_cnt_o(stall_cnt_o), .mc_issue_cnt_o(mc_issue_cnt_o)
`endif
  );

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({fwd_o, stall_o, mc_busy_o, mc_done_o, mc_rd_o} !== {e.f, e.s, e.b, e.d, e.r}) begin
        errors++;
        $display("FAIL %s: got fwd=%b stall=%b busy=%b done=%b rd=%0d, want fwd=%b stall=%b busy=%b done=%b rd=%0d",
                 e.nm, fwd_o, stall_o, mc_busy_o, mc_done_o, mc_rd_o, e.f, e.s, e.b, e.d, e.r);
      end
`ifdef HAZARD_STATS_EN
      if (e.hs) begin
        checks++;
        if ({sc_o, ic_o} !== {e.sc, e.ic}) begin
          errors++;
          $display("FAIL %s_stats: got stall_cnt=%0d issue_cnt=%0d, want %0d %0d",
                   e.nm, sc_o, ic_o, e.sc, e.ic);
        end
      end
`endif
    end

  task automatic chk(input string nm, input logic [3:0] f, input logic s, b, d, input logic [4:0] r,
                     input logic hs = 1'b0, input logic [31:0] sc = 0, input logic [31:0] ic = 0);
    exp_t e;
    e.nm = nm; e.f = f; e.s = s; e.b = b; e.d = d; e.r = r; e.hs = hs; e.sc = sc; e.ic = ic;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_valid_i = 0; id_mc_i = 0; id_rs_i = '0; id_rs_used_i = '0; id_rd_i = '0;
    ex_rs_i = '0; ex_regwrite_i = 0; ex_memread_i = 0; ex_rd_i = '0;
    mem_regwrite_i = 0; mem_rd_i = '0; wb_regwrite_i = 0; wb_rd_i = '0;
  endtask

  initial begin
    clr();
    rst_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'b0000, 0, 0, 0, 5'd0, 1'b1, 0, 0);
    rst_i = 1;
    mem_regwrite_i = 1; mem_rd_i = 5; wb_regwrite_i = 1; wb_rd_i = 5; ex_rs_i = {5'd6, 5'd5};
    chk("fwd_mem_prio", 4'b0010, 0, 0, 0, 5'd0);
    mem_rd_i = 0;
    chk("fwd_wb", 4'b0001, 0, 0, 0, 5'd0);
    ex_rs_i = {5'd5, 5'd5};
    chk("fwd_wb_both", 4'b0101, 0, 0, 0, 5'd0);
    wb_rd_i = 0; ex_rs_i = '0;
    chk("fwd_x0", 4'b0000, 0, 0, 0, 5'd0);
    clr();
    id_valid_i = 1; ex_memread_i = 1; ex_rd_i = 0; id_rs_used_i = 2'b11;
    chk("load_x0", 4'b0000, 0, 0, 0, 5'd0);
    ex_rd_i = 7; id_rs_i = {5'd7, 5'd3};
    chk("load_use", 4'b0000, 1, 0, 0, 5'd0);
    id_rs_used_i = 2'b01;
    chk("load_unused", 4'b0000, 0, 0, 0, 5'd0);
    id_rs_used_i = 2'b11; id_valid_i = 0;
    chk("load_invalid", 4'b0000, 0, 0, 0, 5'd0);
    clr();
    id_valid_i = 1; id_mc_i = 1; id_rd_i = 9;
    chk("mc_issue", 4'b0000, 0, 0, 0, 5'd0);
    id_mc_i = 0; id_rd_i = 0; id_rs_i = {5'd0, 5'd9}; id_rs_used_i = 2'b01;
    chk("mc_raw_t1", 4'b0000, 1, 1, 0, 5'd9);
    chk("mc_raw_t2", 4'b0000, 1, 1, 0, 5'd9);
    chk("mc_done_t3", 4'b0000, 0, 1, 1, 5'd9);
    clr();
    chk("mc_idle_t4", 4'b0000, 0, 0, 0, 5'd9);
    id_valid_i = 1; id_mc_i = 1; id_rd_i = 10;
    chk("b2b_issue", 4'b0000, 0, 0, 0, 5'd9);
    id_rd_i = 11;
    chk("b2b_struct1", 4'b0000, 1, 1, 0, 5'd10);
    chk("b2b_struct2", 4'b0000, 1, 1, 0, 5'd10);
    chk("b2b_done1", 4'b0000, 0, 1, 1, 5'd10);
    clr();
    chk("b2b_busy1", 4'b0000, 0, 1, 0, 5'd11);
    chk("b2b_busy2", 4'b0000, 0, 1, 0, 5'd11);
    id_valid_i = 1; id_rd_i = 11;
    chk("b2b_done2_waw", 4'b0000, 1, 1, 1, 5'd11);
    clr();
    chk("b2b_idle", 4'b0000, 0, 0, 0, 5'd11);
    id_valid_i = 1; id_mc_i = 1; id_rd_i = 12;
    chk("rst_issue", 4'b0000, 0, 0, 0, 5'd11);
    clr();
    rst_i = 0;
    chk("rst_pre", 4'b0000, 0, 1, 0, 5'd12, 1'b1, 6, 4);
    rst_i = 1;
    chk("rst_post1", 4'b0000, 0, 0, 0, 5'd0, 1'b1, 0, 0);
    chk("rst_post2", 4'b0000, 0, 0, 0, 5'd0);
    chk("rst_post3", 4'b0000, 0, 0, 0, 5'd0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
